music_trigger: RTL

- Upstream stage of the Music beeper, which consumes `key` and produces `beep`.
- Merges two play requests into a clean `key` pulse train for Music:
  - the front-panel button (raw, bouncy, asynchronous);
  - the vending FSM's one-cycle `sale_done` strobe.
- Queues requests that arrive while a tune is playing, so every completed sale gets its tune.

---
 rtl/music_trigger_pkg.sv | 41 ++++
 rtl/music_trigger_debounce.sv | 92 +++++++++
 rtl/music_trigger.sv | 139 +++++++++++++
 3 files changed

// File: rtl/music_trigger_pkg.sv
`default_nettype none
// ============================================================================
// | Package     : music_pkg                                                  |
// | Description : Shared types and default constants for the Music beeper    |
// |               front end (music_trigger) and the Music block itself.      |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package music_pkg;

    // Trigger FSM states: waiting, holding key high, waiting out the tune.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEY_ON = 2'd1,
        ST_GAP    = 2'd2
    } trig_state_e;

    // System clock shared with the Music block.
    localparam int unsigned CLK_HZ              = 25_000_000;
    // Button must hold a new level this long before it is believed.
    localparam int unsigned DEBOUNCE_MS         = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
    // Length of one tune in clock cycles; the trigger waits this long.
    localparam int unsigned TUNE_CYCLES         = 1_000_000;
    // Cycles key stays high for each play request.
    localparam int unsigned KEY_HOLD_DEF        = 4;
    // Pending-request counter width.
    localparam int unsigned PEND_W_DEF          = 3;

    // Width of a down/up counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = int'($clog2(n));
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/music_trigger_debounce.sv
`default_nettype none
// ============================================================================
// | Module      : btn_debounce                                               |
// | Description : Front-panel button conditioning: 2-FF synchronizer,       |
// |               optional level debounce and a one-cycle press pulse.       |
// |               MUSIC_TRIG_DEBOUNCE_EN defined   -> debounce counter used. |
// |               MUSIC_TRIG_DEBOUNCE_EN undefined -> synchronized level is  |
// |               taken directly (hardware-debounced boards, fast sims).     |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module btn_debounce
    import music_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_evt_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;        // debounced (or just synchronized) button level
    logic level_prev_q; // level one cycle ago, for press detection

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MUSIC_TRIG_DEBOUNCE_EN
    localparam int unsigned        C_CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    logic               level_q;
    logic               level_d;

    // Count consecutive cycles the synchronized level disagrees with the
    // accepted level; any agreement restarts the count, so bounces never win.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    // No debounce: the synchronized level is already clean.
    assign level = sync2_q;
`endif

    // Remember the previous level so only a press (0->1) yields an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level;
        end
    end

    // One cycle high in the first cycle the accepted level is 1.
    assign btn_evt_o = level & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/music_trigger.sv
`default_nettype none
// ============================================================================
// | Module      : music_trigger                                              |
// | Description : Merges front-panel button presses and vending sale_done    |
// |               strobes into a queued, paced key pulse train for Music.    |
// |               Build option MUSIC_TRIG_DEBOUNCE_EN enables the button     |
// |               debounce counter inside btn_debounce.                      |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module music_trigger
    import music_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned KEY_HOLD        = KEY_HOLD_DEF,
    parameter int unsigned PLAY_GAP        = TUNE_CYCLES,
    parameter int unsigned PEND_W          = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic              sale_done,
    output logic              key,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    // One shared timer serves both the hold phase and the gap phase.
    localparam int unsigned C_HOLD_W = cnt_w(KEY_HOLD);
    localparam int unsigned C_GAP_W  = cnt_w(PLAY_GAP);
    localparam int unsigned C_TMR_W  = (C_HOLD_W > C_GAP_W) ? C_HOLD_W : C_GAP_W;
    localparam logic [C_TMR_W-1:0] C_HOLD_LOAD = C_TMR_W'(KEY_HOLD - 1);
    localparam logic [C_TMR_W-1:0] C_GAP_LOAD  = C_TMR_W'(PLAY_GAP - 1);

    // Two spare bits so pending + 2 arrivals never wraps before saturation.
    localparam int unsigned       C_SUM_W    = PEND_W + 2;
    localparam logic [PEND_W-1:0] C_PEND_MAX = {PEND_W{1'b1}};

    logic                btn_evt;
    logic [1:0]          inc;
    logic                issue;
    logic [C_SUM_W-1:0]  sum;
    logic [PEND_W-1:0]   pending_q;
    logic [PEND_W-1:0]   pending_d;
    logic                drop_q;
    logic                drop_d;

    trig_state_e         state_q;
    logic [C_TMR_W-1:0]  tmr_q;
    logic                key_q;
    logic                busy_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_raw),
        .btn_evt_o (btn_evt)
    );

    // Arrivals this cycle (0..2) and whether the FSM takes a request now.
    assign inc   = {1'b0, btn_evt} + {1'b0, sale_done};
    assign issue = (state_q == ST_IDLE) && (pending_q != '0);
    assign sum   = C_SUM_W'(pending_q) + C_SUM_W'(inc) - C_SUM_W'(issue);

    // Saturating queue update; an overflowing request is reported, not kept.
    always_comb begin
        pending_d = sum[PEND_W-1:0];
        drop_d    = 1'b0;
        if (sum > C_SUM_W'(C_PEND_MAX)) begin
            pending_d = C_PEND_MAX;
            drop_d    = 1'b1;
        end
    end

    // Pending counter and drop pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Request pacing FSM: hold key for KEY_HOLD cycles, then stay busy for
    // PLAY_GAP cycles while the tune plays, then one IDLE cycle at minimum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            key_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q <= ST_KEY_ON;
                        tmr_q   <= C_HOLD_LOAD;
                        key_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_KEY_ON: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_GAP;
                        tmr_q   <= C_GAP_LOAD;
                        key_q   <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - C_TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - C_TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                    key_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key     = key_q;
    assign busy    = busy_q;
    assign pending = pending_q;
    assign drop    = drop_q;

endmodule
`default_nettype wire
